// File: rtl/si_byte_fifo_pkg.sv
// rtl/si_byte_fifo_pkg.sv - shared widths and level-update helper for the SI byte FIFO
package si_byte_fifo_pkg;

  // Word width on the tx_protocol -> UART path
  localparam int TX_WIDTH = 8;
  // log2 of FIFO entry count
  localparam int TX_FIFO_DEPTH_LOG2 = 4;

  typedef enum logic [1:0] {
    LVL_HOLD = 2'd0,
    LVL_INC  = 2'd1,
    LVL_DEC  = 2'd2
  } lvl_op_e;

  // Occupancy change for one cycle; write+pop together leaves the level unchanged
  function automatic lvl_op_e level_op(input logic wr, input logic rd);
    if (wr && !rd) return LVL_INC;
    if (rd && !wr) return LVL_DEC;
    return LVL_HOLD;
  endfunction

endpackage

// File: rtl/si_byte_fifo_if.sv
// rtl/si_byte_fifo_if.sv - SI handshake bundle: upstream write side and downstream read side
interface si_byte_fifo_if
  import si_byte_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = TX_WIDTH
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_rdy;
  logic                  in_ack;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_rdy;
  logic                  out_ack;

  // FIFO side
  modport slave (
    input  in_data, in_rdy, out_ack,
    output in_ack, out_data, out_rdy
  );

  // Producer/consumer side
  modport master (
    output in_data, in_rdy, out_ack,
    input  in_ack, out_data, out_rdy
  );
endinterface

// File: rtl/si_fifo_mem.sv
// rtl/si_fifo_mem.sv - register-array storage with one write port and an async read port
module si_fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Contents need no reset; occupancy is tracked by the controller
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/si_byte_fifo.sv
// rtl/si_byte_fifo.sv - SI byte FIFO tx_protocol->UART; SI_FIFO_STATS_EN adds high-watermark
module si_byte_fifo
  import si_byte_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = TX_WIDTH,
  parameter int DEPTH_LOG2 = TX_FIFO_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  rst,
  si_byte_fifo_if.slave         si,
  input  logic                  flush,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   max_level
);
  localparam int DEPTH = 2**DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   DEPTH_LVL = DEPTH[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = 1;
  localparam logic [DEPTH_LOG2:0]   LVL_ONE   = 1;

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic                  in_ack_q, in_ack_d;
  logic                  wr_en;
  logic                  pop;
  logic [DATA_WIDTH-1:0] rdata;

  // full/empty come from the level counter so pointer equality is never ambiguous
  assign full  = (level_q == DEPTH_LVL);
  assign empty = (level_q == '0);

  // A word acked in a flush cycle is dropped; pops on empty or during flush are ignored
  assign wr_en = in_ack_q & ~flush;
  assign pop   = si.out_ack & ~empty & ~flush;

  // Next-state for handshake, pointers and occupancy
  always_comb begin
    // Ack only on a fresh offer with room judged from the prior level;
    // the previous ack blocks a second one, so one pending write at most
    in_ack_d = si.in_rdy & ~in_ack_q & ~full & ~flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)   rd_ptr_d = rd_ptr_q + PTR_ONE;
      case (level_op(wr_en, pop))
        LVL_INC: level_d = level_q + LVL_ONE;
        LVL_DEC: level_d = level_q - LVL_ONE;
        default: level_d = level_q;
      endcase
    end
  end

  // Control state registers; reset drops any pending ack so upstream re-offers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      in_ack_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      in_ack_q <= in_ack_d;
    end
  end

  si_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (DEPTH_LOG2)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr_q),
    .wdata (si.in_data),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );

  assign si.in_ack   = in_ack_q;
  assign si.out_rdy  = ~empty;
  // Head word is presented as zero while empty so reset shows a clean bus
  assign si.out_data = empty ? '0 : rdata;
  assign level       = level_q;

`ifdef SI_FIFO_STATS_EN
  logic [DEPTH_LOG2:0] max_level_q;

  // High-watermark of the post-update level; cleared with the queue
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      max_level_q <= '0;
    end else if (flush) begin
      max_level_q <= '0;
    end else if (level_d > max_level_q) begin
      max_level_q <= level_d;
    end
  end

  assign max_level = max_level_q;
`else
  assign max_level = '0;
`endif

endmodule

// File: tb/tb_si_byte_fifo.sv
// tb/tb_si_byte_fifo.sv - randomized self-checking bench for si_byte_fifo against a queue model
module tb_si_byte_fifo;
`ifdef SI_FIFO_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       flush = 1'b0;
  logic [4:0] level;
  logic       full;
  logic       empty;
  logic [4:0] max_level;

  si_byte_fifo_if #(.DATA_WIDTH(8)) sif ();

  si_byte_fifo #(.DATA_WIDTH(8), .DEPTH_LOG2(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .si        (sif),
    .flush     (flush),
    .level     (level),
    .full      (full),
    .empty     (empty),
    .max_level (max_level)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] q[$];
  logic [7:0] src[$];
  logic [7:0] poplog[$];
  bit         exp_ack = 1'b0;
  int         exp_max = 0;
  int         n_acks = 0;
  logic [7:0] last_acked = 8'h00;
  int         max_seen = 0;
  int         sz;
  bit         ack;

  // Upstream producer: offers the head of src, moves on once it has seen an ack
  initial begin
    sif.in_rdy  = 1'b0;
    sif.in_data = 8'h00;
    sif.out_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      sif.in_rdy  = (src.size() > 0);
      sif.in_data = (src.size() > 0) ? src[0] : 8'h00;
    end
  end

  // Scoreboard: compare against the queue model, then apply this cycle's handshakes
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (sif.in_ack !== 1'b0 || sif.out_rdy !== 1'b0 || empty !== 1'b1 || full !== 1'b0 ||
          level !== 5'd0 || sif.out_data !== 8'h00 || max_level !== 5'd0) begin
        errors++;
        $display("FAIL reset_state: got ack=%b rdy=%b empty=%b full=%b level=%0d data=%h max=%0d expected 0 0 1 0 0 00 0",
                 sif.in_ack, sif.out_rdy, empty, full, level, sif.out_data, max_level);
      end
      q.delete();
      exp_ack = 1'b0;
      exp_max = 0;
    end else begin
      checks++;
      if (sif.in_ack !== exp_ack) begin
        errors++; $display("FAIL in_ack: got %b expected %b", sif.in_ack, exp_ack);
      end
      checks++;
      if (level !== 5'(q.size())) begin
        errors++; $display("FAIL level: got %0d expected %0d", level, q.size());
      end
      checks++;
      if (full !== (q.size() == 16)) begin
        errors++; $display("FAIL full: got %b expected %b", full, q.size() == 16);
      end
      checks++;
      if (empty !== (q.size() == 0)) begin
        errors++; $display("FAIL empty: got %b expected %b", empty, q.size() == 0);
      end
      checks++;
      if (sif.out_rdy !== (q.size() != 0)) begin
        errors++; $display("FAIL out_rdy: got %b expected %b", sif.out_rdy, q.size() != 0);
      end
      if (q.size() > 0) begin
        checks++;
        if (sif.out_data !== q[0]) begin
          errors++; $display("FAIL out_data: got %h expected %h", sif.out_data, q[0]);
        end
      end
      checks++;
      if (max_level !== 5'(exp_max)) begin
        errors++; $display("FAIL max_level: got %0d expected %0d", max_level, exp_max);
      end
      if (int'(level) > max_seen) max_seen = int'(level);

      sz  = q.size();
      ack = sif.in_ack;
      if (sif.out_ack && sif.out_rdy && !flush) poplog.push_back(sif.out_data);
      if (flush) begin
        q.delete();
      end else begin
        if (sif.out_ack && sz > 0) void'(q.pop_front());
        if (ack) q.push_back(sif.in_data);
      end
      if (ack) begin
        last_acked = sif.in_data;
        n_acks++;
        if (src.size() > 0) void'(src.pop_front());
      end
      exp_ack = sif.in_rdy && !ack && (sz < 16) && !flush;
      if (STATS) exp_max = flush ? 0 : ((q.size() > exp_max) ? q.size() : exp_max);
    end
  end

  task automatic step(input bit oack, input bit fl);
    sif.out_ack = oack;
    flush = fl;
    @(posedge clk);
    #2;
  endtask

  task automatic drain();
    for (int i = 0; i < 600 && (q.size() > 0 || src.size() > 0); i++) step(1'b1, 1'b0);
    checks++;
    if (q.size() > 0 || src.size() > 0) begin
      errors++; $display("FAIL drain_timeout: got %0d words left expected 0", q.size() + src.size());
    end
    checks++;
    if (empty !== 1'b1) begin
      errors++; $display("FAIL drain_empty: got %b expected 1", empty);
    end
  endtask

  task automatic test_reset();
    src.push_back(8'h3C);
    rst = 1'b0;
    repeat (3) step(1'b0, 1'b0);
    checks++;
    if (sif.in_ack !== 1'b0 || level !== 5'd0) begin
      errors++; $display("FAIL reset_hold: got ack=%b level=%0d expected 0 0", sif.in_ack, level);
    end
    rst = 1'b1;
    step(1'b0, 1'b0);
    checks++;
    if (sif.in_ack !== 1'b1) begin
      errors++; $display("FAIL first_ack: got %b expected 1", sif.in_ack);
    end
    step(1'b0, 1'b0);
    checks++;
    if (sif.out_rdy !== 1'b1 || sif.out_data !== 8'h3C) begin
      errors++; $display("FAIL first_word: got rdy=%b data=%h expected 1 3c", sif.out_rdy, sif.out_data);
    end
    drain();
  endtask

  task automatic test_fill();
    int a0;
    a0 = n_acks;
    for (int i = 0; i < 20; i++) src.push_back(8'(i));
    repeat (60) step(1'b0, 1'b0);
    checks++;
    if (n_acks - a0 != 16) begin
      errors++; $display("FAIL fill_acks: got %0d expected 16", n_acks - a0);
    end
    checks++;
    if (full !== 1'b1 || level !== 5'd16 || sif.in_ack !== 1'b0) begin
      errors++; $display("FAIL fill_full: got full=%b level=%0d ack=%b expected 1 16 0", full, level, sif.in_ack);
    end
    a0 = n_acks;
    step(1'b1, 1'b0);
    for (int i = 0; i < 10 && n_acks == a0; i++) step(1'b0, 1'b0);
    checks++;
    if (n_acks != a0 + 1 || last_acked !== 8'h10) begin
      errors++; $display("FAIL fill_next_ack: got acks=%0d word=%h expected 1 10", n_acks - a0, last_acked);
    end
    drain();
  endtask

  task automatic test_order_wrap();
    poplog.delete();
    max_seen = 0;
    for (int i = 0; i < 40; i++) src.push_back(8'(8'hA0 + i));
    for (int i = 0; i < 600 && (q.size() > 0 || src.size() > 0); i++) step(i % 3 == 2, 1'b0);
    checks++;
    if (poplog.size() != 40) begin
      errors++; $display("FAIL wrap_count: got %0d expected 40", poplog.size());
    end
    for (int j = 0; j < 40 && j < poplog.size(); j++) begin
      checks++;
      if (poplog[j] !== 8'(8'hA0 + j)) begin
        errors++; $display("FAIL wrap_order[%0d]: got %h expected %h", j, poplog[j], 8'(8'hA0 + j));
      end
    end
    checks++;
    if (max_seen > 16) begin
      errors++; $display("FAIL wrap_max_level: got %0d expected <=16", max_seen);
    end
    drain();
  endtask

  task automatic test_simultaneous();
    logic [7:0] nh;
    for (int i = 0; i < 6; i++) src.push_back(8'($urandom));
    for (int i = 0; i < 100 && !(q.size() == 5 && exp_ack); i++) step(1'b0, 1'b0);
    checks++;
    if (level !== 5'd5 || sif.in_ack !== 1'b1) begin
      errors++; $display("FAIL simul_setup: got level=%0d ack=%b expected 5 1", level, sif.in_ack);
    end
    nh = (q.size() > 1) ? q[1] : 8'h00;
    step(1'b1, 1'b0);
    checks++;
    if (level !== 5'd5 || sif.out_data !== nh) begin
      errors++; $display("FAIL simul_result: got level=%0d head=%h expected 5 %h", level, sif.out_data, nh);
    end
    drain();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 10; i++) src.push_back(8'($urandom));
    for (int i = 0; i < 100 && !(q.size() == 9 && exp_ack); i++) step(1'b0, 1'b0);
    checks++;
    if (level !== 5'd9 || sif.in_ack !== 1'b1) begin
      errors++; $display("FAIL flush_setup: got level=%0d ack=%b expected 9 1", level, sif.in_ack);
    end
    step(1'b0, 1'b1);
    checks++;
    if (level !== 5'd0 || empty !== 1'b1 || max_level !== 5'd0 || sif.in_ack !== 1'b0) begin
      errors++; $display("FAIL flush_clear: got level=%0d empty=%b max=%0d ack=%b expected 0 1 0 0",
                         level, empty, max_level, sif.in_ack);
    end
    src.push_back(8'h55);
    for (int i = 0; i < 20 && q.size() == 0; i++) step(1'b0, 1'b0);
    checks++;
    if (sif.out_data !== 8'h55 || level !== 5'd1) begin
      errors++; $display("FAIL flush_after: got data=%h level=%0d expected 55 1", sif.out_data, level);
    end
    drain();
  endtask

  task automatic test_stats();
    for (int i = 0; i < 12; i++) src.push_back(8'($urandom));
    for (int i = 0; i < 100 && q.size() < 12; i++) step(1'b0, 1'b0);
    for (int i = 0; i < 40 && q.size() > 3; i++) step(1'b1, 1'b0);
    checks++;
    if (level !== 5'd3 || max_level !== (STATS ? 5'd12 : 5'd0)) begin
      errors++; $display("FAIL stats_max: got level=%0d max=%0d expected 3 %0d", level, max_level, STATS ? 12 : 0);
    end
    drain();
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    checks++;
    if (max_level !== 5'd0) begin
      errors++; $display("FAIL stats_flush: got %0d expected 0", max_level);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 2) == 0 && src.size() < 24) src.push_back(8'($urandom));
      step(1'($urandom_range(0, 1)), $urandom_range(0, 63) == 0);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 10; i++) src.push_back(8'($urandom));
    for (int i = 0; i < 15; i++) step(1'($urandom_range(0, 3) == 0), 1'b0);
    rst = 1'b0;
    #1;
    checks++;
    if (level !== 5'd0 || sif.in_ack !== 1'b0 || sif.out_rdy !== 1'b0 || empty !== 1'b1) begin
      errors++; $display("FAIL async_reset: got level=%0d ack=%b rdy=%b empty=%b expected 0 0 0 1",
                         level, sif.in_ack, sif.out_rdy, empty);
    end
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    rst = 1'b1;
    drain();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_order_wrap();
    test_simultaneous();
    test_flush();
    test_stats();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before 500000");
    $fatal(1, "watchdog expired");
  end
endmodule
